// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (WB) control
// with program counter and retired-instruction counter.
module instr_sequencer #(
   parameter int PC_W     = 16,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            halt_req,
   output logic            imem_req,
   input  logic            imem_ready,
   input  logic [3:0]      opcode,
   output logic            alu_start,
   input  logic            alu_done,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   output logic            ir_load,
   output logic            imm_sel,
   output logic            rf_we,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;
   typedef enum logic [1:0] {C_R, C_I, C_B} cls_t;

   state_t           r_state, w_next;
   cls_t             r_cls, w_cls;
   logic             r_first;
   logic [PC_W-1:0]  r_pc, w_pc_nxt, w_pc_inc;
   logic [CNT_W-1:0] r_retired;
   logic             w_pc_en;

   assign w_pc_inc = r_pc + PC_W'(1);

   always_comb begin
      w_cls = C_B;
      if (opcode <= 4'd8)       w_cls = C_R;
      else if (opcode <= 4'd11) w_cls = C_I;
   end

   always_comb begin
      w_next    = r_state;
      imem_req  = 1'b0;
      ir_load   = 1'b0;
      alu_start = 1'b0;
      imm_sel   = 1'b0;
      rf_we     = 1'b0;
      w_pc_en   = 1'b0;
      w_pc_nxt  = w_pc_inc;
      case (r_state)
         S_IDLE:   if (start) w_next = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_load = 1'b1;
               w_next  = S_DECODE;
            end
         end
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            alu_start = r_first;
            imm_sel   = (r_cls == C_I);
            if (alu_done) begin
               if (r_cls == C_B) begin
                  // branches retire here; this is their boundary cycle
                  w_pc_en  = 1'b1;
                  w_pc_nxt = branch_taken ? branch_target : w_pc_inc;
                  w_next   = halt_req ? S_IDLE : S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            w_pc_en = 1'b1;
            w_next  = halt_req ? S_IDLE : S_FETCH;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cls     <= C_R;
         r_first   <= 1'b0;
         r_pc      <= PC_W'(RESET_PC);
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         r_first <= (r_state == S_DECODE);
         if (r_state == S_DECODE) r_cls <= w_cls;
         if (w_pc_en) begin
            r_pc      <= w_pc_nxt;
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

   assign pc      = r_pc;
   assign retired = r_retired;
   assign busy    = (r_state != S_IDLE);

endmodule
